ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter that sends one command byte (set LEDs 0xED, reset 0xFF, enable 0xF4, …) from the FPGA to the keyboard. It is the opposite direction of `keyboard_tracker`, which only receives. It shares the open-drain `PS2_CLK`/`PS2_DAT` pins with that receiver and drives them low through output enables generated at the top level. It raises `busy` so the receiver ignores the bus while a host frame is in flight.

---
 rtl/ps2_pkg.sv | 33 +++
 rtl/ps2_sync_edge.sv | 24 ++
 rtl/ps2_host_tx.sv | 171 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM states, transfer status codes and common
// keyboard command bytes.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    SEND,
    WAIT_IDLE,
    FINISH
  } state_e;

  typedef enum logic [1:0] {
    STATUS_ACK     = 2'b00,
    STATUS_NACK    = 2'b01,
    STATUS_TIMEOUT = 2'b10
  } status_e;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] ACK_BYTE     = 8'hFA;

  // Frame bit positions: 1..8 data, 9 parity, 10 stop, 11 device ack.
  localparam logic [3:0] BIT_PARITY = 4'd9;
  localparam logic [3:0] BIT_ACK    = 4'd11;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for an asynchronous PS/2 pin, with a one-cycle
// falling-edge pulse taken from the second stage against a delayed copy.
module ps2_sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic level_o,
  output logic fall_o
);

  logic [2:0] sync_q;

  // NOTE: non-blocking assignment so each stage captures its neighbour's
  // pre-edge value; blocking here would collapse the chain into one flop.
  // Stages preset to 1 so the pulled-up idle bus never looks like a fall.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync_q <= 3'b111;
    else       sync_q <= {sync_q[1:0], d_i};
  end

  assign level_o = sync_q[1];
  assign fall_o  = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a start bit, then
// shifts one command byte out on device clock falling edges and checks the ack.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int INHIBIT_CYCLES = 6000,
  parameter int START_CYCLES   = 250,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic [1:0] status
);

  localparam int PHASE_MAX = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
  localparam int PW        = $clog2(PHASE_MAX + 1);
  localparam int TW        = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [PW-1:0] INHIBIT_LAST = PW'(INHIBIT_CYCLES - 1);
  localparam logic [PW-1:0] START_LAST   = PW'(START_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  if (CLK_HZ <= 0 || INHIBIT_CYCLES < 1 || START_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("ps2_host_tx: invalid parameters");
  end

  logic clk_lvl, clk_fall, dat_lvl, dat_fall_unused;

  ps2_sync_edge u_clk_sync (
    .clock   (clock),
    .reset   (reset),
    .d_i     (ps2_clk_in),
    .level_o (clk_lvl),
    .fall_o  (clk_fall)
  );

  ps2_sync_edge u_dat_sync (
    .clock   (clock),
    .reset   (reset),
    .d_i     (ps2_dat_in),
    .level_o (dat_lvl),
    .fall_o  (dat_fall_unused)
  );

  state_e        state_q, state_d;
  status_e       status_q, status_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic          parity_q, parity_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      status_q <= STATUS_ACK;
      phase_q  <= '0;
      tmo_q    <= '0;
      bit_q    <= '0;
      data_q   <= '0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      phase_q  <= phase_d;
      tmo_q    <= tmo_d;
      bit_q    <= bit_d;
      data_q   <= data_d;
      parity_q <= parity_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    status_d   = status_q;
    phase_d    = phase_q;
    tmo_d      = tmo_q;
    bit_d      = bit_q;
    data_d     = data_q;
    parity_d   = parity_q;
    ps2_clk_oe = 1'b0;
    ps2_dat_oe = 1'b0;
    done       = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          data_d   = cmd_data;
          parity_d = odd_parity(cmd_data);
          phase_d  = '0;
          state_d  = INHIBIT;
        end
      end

      INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (phase_q == INHIBIT_LAST) begin
          phase_d = '0;
          state_d = START;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      START: begin
        ps2_clk_oe = 1'b1;
        ps2_dat_oe = 1'b1;
        if (phase_q == START_LAST) begin
          tmo_d   = '0;
          bit_d   = '0;
          state_d = SEND;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      SEND: begin
        // Bit 0 keeps the start bit on the line until the first device fall.
        if (bit_q == 4'd0)              ps2_dat_oe = 1'b1;
        else if (bit_q < BIT_PARITY)    ps2_dat_oe = ~data_q[3'(bit_q - 4'd1)];
        else if (bit_q == BIT_PARITY)   ps2_dat_oe = ~parity_q;
        tmo_d = tmo_q + 1'b1;
        if (clk_fall) begin
          tmo_d = '0;
          bit_d = (bit_q == BIT_ACK) ? bit_q : bit_q + 4'd1;
          if (bit_q == BIT_ACK - 4'd1) begin
            status_d = dat_lvl ? STATUS_NACK : STATUS_ACK;
            state_d  = WAIT_IDLE;
          end
        end else if (tmo_q == TIMEOUT_LAST) begin
          status_d = STATUS_TIMEOUT;
          state_d  = FINISH;
        end
      end

      WAIT_IDLE: begin
        tmo_d = tmo_q + 1'b1;
        if (clk_lvl && dat_lvl) begin
          state_d = FINISH;
        end else if (tmo_q == TIMEOUT_LAST) begin
          status_d = STATUS_TIMEOUT;
          state_d  = FINISH;
        end
      end

      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign status    = status_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a vector table of whole frames against a
// simple PS/2 device model, plus timeout and mid-frame reset sequences.
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int STR = 5;
  localparam int TMO = 400;
  localparam int HALF = 40;

  logic       clk;
  logic       rst;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       busy, done;
  logic [1:0] status;
  logic       dev_clk, dev_dat;
  logic       ps2_clk_in, ps2_dat_in;

  // Open-drain bus: low if either side pulls, otherwise pulled up.
  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(
    .CLK_HZ         (50_000_000),
    .INHIBIT_CYCLES (INH),
    .START_CYCLES   (STR),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock      (clk),
    .reset      (rst),
    .cmd_data   (cmd_data),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .busy       (busy),
    .done       (done),
    .status     (status)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec  = 0;
  int n_miss = 0;
  int done_cnt = 0;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic       nack;
    logic       poke;
    logic       exp_parity;
    logic [1:0] exp_status;
  } vec_t;

  vec_t vecs[5];

  // Accepts a command and checks the inhibit/start phase cycle by cycle.
  // Returns on the first SEND cycle (clock just released).
  task automatic start_frame(input logic [7:0] cmd, input string tag);
    int first_bad;
    logic exp_c, exp_d;
    @(negedge clk);
    cmd_data  = cmd;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check({tag, " ready/busy after accept"}, {31'd0, cmd_ready, busy}, 32'b01);
    first_bad = 0;
    for (int k = 1; k <= INH + STR + 1; k++) begin
      if (k > 1) @(negedge clk);
      exp_c = (k <= INH + STR);
      exp_d = (k >= INH + 1);
      if ((ps2_clk_oe !== exp_c || ps2_dat_oe !== exp_d) && first_bad == 0) first_bad = k;
    end
    check({tag, " first cycle with wrong OEs in inhibit/start"}, first_bad, 0);
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    logic [10:0] bits;
    logic [7:0]  byte_got;
    bit          seen;
    int          base;
    base = done_cnt;
    start_frame(v.cmd, tag);
    repeat (HALF) @(negedge clk);
    bits[0] = ps2_dat_in;
    for (int k = 1; k <= 10; k++) begin
      dev_clk = 1'b0;
      if (v.poke && k == 5) begin
        @(negedge clk);
        cmd_data  = 8'h00;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (HALF - 2) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      dev_clk = 1'b1;
      bits[k] = ps2_dat_in;
      repeat (HALF) @(negedge clk);
    end
    dev_dat = v.nack;
    repeat (HALF / 2) @(negedge clk);
    dev_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    dev_clk = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i == 10) dev_dat = 1'b1;
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    dev_dat = 1'b1;
    for (int k = 1; k <= 8; k++) byte_got[k-1] = bits[k];
    check({tag, " start bit"}, {31'd0, bits[0]}, 32'd0);
    check({tag, " data byte"}, {24'd0, byte_got}, {24'd0, v.cmd});
    check({tag, " parity bit"}, {31'd0, bits[9]}, {31'd0, v.exp_parity});
    check({tag, " stop bit"}, {31'd0, bits[10]}, 32'd1);
    check({tag, " done seen"}, {31'd0, seen}, 32'd1);
    check({tag, " status at done"}, {30'd0, status}, {30'd0, v.exp_status});
    check({tag, " OEs and ready at done"}, {29'd0, ps2_clk_oe, ps2_dat_oe, cmd_ready}, 32'd0);
    @(negedge clk);
    check({tag, " ready/busy after done"}, {30'd0, cmd_ready, busy}, 32'b10);
    repeat (20) @(negedge clk);
    check({tag, " done pulse count"}, done_cnt - base, 1);
  endtask

  initial begin
    int   cnt;
    bit   seen;
    vec_t v_ff;

    vecs[0] = '{cmd: 8'hF4, nack: 1'b0, poke: 1'b0, exp_parity: 1'b0, exp_status: 2'b00};
    vecs[1] = '{cmd: 8'hED, nack: 1'b0, poke: 1'b0, exp_parity: 1'b1, exp_status: 2'b00};
    vecs[2] = '{cmd: 8'h01, nack: 1'b0, poke: 1'b0, exp_parity: 1'b0, exp_status: 2'b00};
    vecs[3] = '{cmd: 8'hF4, nack: 1'b0, poke: 1'b1, exp_parity: 1'b0, exp_status: 2'b00};
    vecs[4] = '{cmd: 8'hFF, nack: 1'b1, poke: 1'b0, exp_parity: 1'b1, exp_status: 2'b01};

    rst       = 1'b1;
    cmd_data  = 8'h00;
    cmd_valid = 1'b0;
    dev_clk   = 1'b1;
    dev_dat   = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset outputs {ready,busy,clk_oe,dat_oe,done}",
          {27'd0, cmd_ready, busy, ps2_clk_oe, ps2_dat_oe, done}, 32'b10000);
    check("reset status", {30'd0, status}, 32'd0);

    for (int i = 0; i < 5; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

    // Device never clocks: done must land TMO cycles after clock release.
    start_frame(8'hF4, "timeout");
    cnt  = 0;
    seen = 1'b0;
    while (cnt < 1000) begin
      @(negedge clk);
      cnt++;
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("timeout done seen", {31'd0, seen}, 32'd1);
    check("timeout cycles from release to done", cnt, TMO);
    check("timeout status", {30'd0, status}, 32'b10);
    check("timeout OEs at done", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    repeat (5) @(negedge clk);

    // Reset while the fifth bit (a 0 bit of 0xED) is on the line.
    start_frame(8'hED, "reset");
    repeat (HALF) @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    dev_clk = 1'b0;
    repeat (10) @(negedge clk);
    check("pre-reset dat_oe driving bit 5", {31'd0, ps2_dat_oe}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async reset {clk_oe,dat_oe,busy,done}", {28'd0, ps2_clk_oe, ps2_dat_oe, busy, done}, 32'd0);
    check("async reset ready/status", {29'd0, cmd_ready, status}, 32'b100);
    @(negedge clk);
    dev_clk = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    v_ff = '{cmd: 8'hFF, nack: 1'b0, poke: 1'b0, exp_parity: 1'b1, exp_status: 2'b00};
    run_frame(v_ff, "post-reset 0xFF");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
